background_writer: RTL

- Fills the 8-bit-per-pixel background frame memory that the display-side background reader scans out at address DrawX + DrawY*WIDTH.
- Two modes:
  - LOAD: a valid/ready byte stream, such as an SD or UART image loader, is written in raster order.
  - FILL: one colour is written to every pixel.
- Drives a single write port, one write per clock, at the same address layout the reader uses.

---
 rtl/background_writer_pkg.sv | 22 ++
 rtl/background_writer_raster_addr_counter.sv | 72 +++++++
 rtl/background_writer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/background_writer_pkg.sv
// Shared types and default geometry for the background frame writer.
// Pure declarations: no latency or flow control of its own.
package bg_writer_pkg;

    localparam int BG_WIDTH  = 640;
    localparam int BG_HEIGHT = 480;
    localparam int BG_ADDR_W = 19;
    localparam int BG_PIXELS = BG_WIDTH * BG_HEIGHT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } bg_wr_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/background_writer_raster_addr_counter.sv
// Raster position counter (x, y, linear addr) stepped once per write; clear wins over inc.
// Registered, zero-latency outputs; no backpressure, the caller gates inc.
module raster_addr_counter
    import bg_writer_pkg::*;
#(
    parameter int WIDTH  = BG_WIDTH,
    parameter int HEIGHT = BG_HEIGHT,
    parameter int ADDR_W = BG_ADDR_W
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         clear,
    input  logic                         inc,
    output logic [cnt_width(WIDTH)-1:0]  x,
    output logic [cnt_width(HEIGHT)-1:0] y,
    output logic [ADDR_W-1:0]            addr,
    output logic                         last
);

    localparam int X_W = cnt_width(WIDTH);
    localparam int Y_W = cnt_width(HEIGHT);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              end_of_line;

    assign end_of_line = (x_q == X_W'(WIDTH - 1));
    assign last        = end_of_line && (y_q == Y_W'(HEIGHT - 1));

    // addr tracks x + y*WIDTH purely by increment, so no multiplier is needed.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (inc) begin
            if (last) begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
            end else if (end_of_line) begin
                x_d    = '0;
                y_d    = y_q + Y_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                x_d    = x_q + X_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign addr = addr_q;

endmodule

// File: rtl/background_writer.sv
// Writes a background frame from a byte stream (LOAD) or a single colour (FILL).
// Write port is one cycle behind each accept; pix_ready is high throughout LOAD.
module background_writer
    import bg_writer_pkg::*;
#(
    parameter int WIDTH  = BG_WIDTH,
    parameter int HEIGHT = BG_HEIGHT,
    parameter int ADDR_W = BG_ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start_load,
    input  logic              start_fill,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    bg_wr_state_t      state_q, state_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic                         cnt_clear;
    logic                         cnt_inc;
    logic                         cnt_last;
    logic [ADDR_W-1:0]            cnt_addr;
    logic [cnt_width(WIDTH)-1:0]  cnt_x;
    logic [cnt_width(HEIGHT)-1:0] cnt_y;

    raster_addr_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .x     (cnt_x),
        .y     (cnt_y),
        .addr  (cnt_addr),
        .last  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        color_d   = color_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d   = LOAD;
                    cnt_clear = 1'b1;
                end else if (start_fill) begin
                    state_d   = FILL;
                    color_d   = fill_color;
                    cnt_clear = 1'b1;
                end
            end
            LOAD: begin
                // An accept coinciding with abort is deliberately dropped.
                if (abort) begin
                    state_d = IDLE;
                end else if (pix_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_addr;
                    wr_data_d = pix_data;
                    cnt_inc   = 1'b1;
                    if (cnt_last) state_d = DONE;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_addr;
                    wr_data_d = color_q;
                    cnt_inc   = 1'b1;
                    if (cnt_last) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            color_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            color_q   <= color_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign pix_ready = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == FILL);
    assign done      = (state_q == DONE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
